// File: rtl/trigger_chain_design.sv
// Two-stage cascaded 8-sample-parallel biquad notch filter for the trigger path.
// Coefficients are loaded over Wishbone into per-stage shadow banks and go live on an update write.

module trigger_chain_stage #(
    parameter int NSAMP = 8,
    parameter int NBITS = 12,
    parameter int CBITS = 18,
    parameter int FRAC  = 14,
    parameter int NCOEF = 25
) (
    input  logic                     aclk,
    input  logic                     reset_BQ_i,
    input  logic [NCOEF*CBITS-1:0]   coef,
    input  logic [NSAMP*NBITS-1:0]   x,
    output logic [NSAMP*NBITS-1:0]   y
);
    typedef logic signed [47:0] acc_t;
    localparam int SMAX_I = (1 << (NBITS - 1)) - 1;
    localparam int SMIN_I = -(1 << (NBITS - 1));

    function automatic acc_t sext_smp(input logic [NBITS-1:0] v);
        return {{(48-NBITS){v[NBITS-1]}}, v};
    endfunction

    function automatic acc_t sext_coef(input logic [CBITS-1:0] v);
        return {{(48-CBITS){v[CBITS-1]}}, v};
    endfunction

    function automatic logic [NBITS-1:0] sat(input acc_t v);
        logic [NBITS-1:0] r;
        if (v > acc_t'(SMAX_I)) begin
            r = {1'b0, {(NBITS-1){1'b1}}};
        end else if (v < acc_t'(SMIN_I)) begin
            r = {1'b1, {(NBITS-1){1'b0}}};
        end else begin
            r = v[NBITS-1:0];
        end
        return r;
    endfunction

    acc_t             c_s   [NCOEF];
    acc_t             xe_s  [NSAMP+2];
    acc_t             z_s   [NSAMP];
    acc_t             z_r   [NSAMP];
    acc_t             ym1_s, ym2_s, f_sum_s, g_sum_s;
    logic [NBITS-1:0] yq_s  [NSAMP];
    logic [NBITS-1:0] y_r   [NSAMP];
    logic [NBITS-1:0] xh6_r, xh7_r;

    // Unpack coefficients and compute the zero section; xe_s[0..1] is the previous block's x6/x7
    always_comb begin
        for (int k = 0; k < NCOEF; k++) begin
            c_s[k] = sext_coef(coef[k*CBITS +: CBITS]);
        end
        xe_s[0] = sext_smp(xh6_r);
        xe_s[1] = sext_smp(xh7_r);
        for (int n = 0; n < NSAMP; n++) begin
            xe_s[n+2] = sext_smp(x[n*NBITS +: NBITS]);
        end
        for (int n = 0; n < NSAMP; n++) begin
            z_s[n] = xe_s[n+2] + ((c_s[0] * xe_s[n+1] + c_s[1] * xe_s[n]) >>> FRAC);
        end
    end

    // Look-ahead pole section; coefficient slots follow the sequenced write order of each register
    always_comb begin
        ym1_s = sext_smp(y_r[7]);
        ym2_s = sext_smp(y_r[6]);
        for (int n = 0; n < NSAMP; n++) begin
            yq_s[n] = '0;
        end
        yq_s[0] = sat(z_r[0] + ((c_s[5] * ym1_s + c_s[4] * ym2_s) >>> FRAC));
        yq_s[1] = sat(z_r[1] + ((c_s[2] * ym1_s + c_s[3] * ym2_s + c_s[6] * z_r[0]) >>> FRAC));
        for (int n = 2; n < 6; n++) begin
            yq_s[n] = sat(z_r[n] + ((c_s[6] * sext_smp(yq_s[n-1])
                                     + c_s[7] * sext_smp(yq_s[n-2])) >>> FRAC));
        end
        f_sum_s = c_s[8] * ym2_s + c_s[24] * ym1_s;
        for (int k = 1; k <= 6; k++) begin
            f_sum_s = f_sum_s + c_s[15-k] * z_r[6-k];
        end
        yq_s[6] = sat(z_r[6] + (f_sum_s >>> FRAC));
        g_sum_s = c_s[15] * ym1_s + c_s[23] * ym2_s;
        for (int k = 1; k <= 7; k++) begin
            g_sum_s = g_sum_s + c_s[23-k] * z_r[7-k];
        end
        yq_s[7] = sat(z_r[7] + (g_sum_s >>> FRAC));
    end

    // Two pipeline registers: zero-section result, then saturated stage output
    always_ff @(posedge aclk or posedge reset_BQ_i) begin
        if (reset_BQ_i) begin
            xh6_r <= '0;
            xh7_r <= '0;
            for (int n = 0; n < NSAMP; n++) begin
                z_r[n] <= 48'sd0;
                y_r[n] <= '0;
            end
        end else begin
            xh6_r <= x[6*NBITS +: NBITS];
            xh7_r <= x[7*NBITS +: NBITS];
            for (int n = 0; n < NSAMP; n++) begin
                z_r[n] <= z_s[n];
                y_r[n] <= yq_s[n];
            end
        end
    end

    // Pack the registered outputs
    always_comb begin
        y = '0;
        for (int n = 0; n < NSAMP; n++) begin
            y[n*NBITS +: NBITS] = y_r[n];
        end
    end
endmodule

module trigger_chain_design #(
    parameter int NSAMP = 8,
    parameter int NBITS = 12,
    parameter int CBITS = 18,
    parameter int FRAC  = 14
) (
    input  logic                   aclk,
    input  logic                   reset_BQ_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_sel_i,
    input  logic [7:0]             wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    output logic                   wb_ack_o,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    input  logic [NSAMP*NBITS-1:0] dat_i,
    output logic [NSAMP*NBITS-1:0] dat_o
);
    localparam int NCOEF = 25;

    function automatic logic [4:0] seq_base(input logic [2:0] r);
        case (r)
            3'd0:    return 5'd0;
            3'd1:    return 5'd2;
            3'd2:    return 5'd6;
            3'd3:    return 5'd8;
            3'd4:    return 5'd15;
            3'd5:    return 5'd23;
            3'd6:    return 5'd24;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [2:0] seq_last(input logic [2:0] r);
        case (r)
            3'd0:    return 3'd1;
            3'd1:    return 3'd3;
            3'd2:    return 3'd1;
            3'd3:    return 3'd6;
            3'd4:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    logic                   ack_r, req_s, wr_s, bank_s, seq_hit_s, upd_cmd_s, unused_s;
    logic [2:0]             seq_idx_s;
    logic [4:0]             wr_idx_s;
    logic [2:0]             ptr_r    [2][7];
    // No reset and no init: coefficient banks rely on the zero power-up state of the device
    logic [CBITS-1:0]       shadow_r [2][NCOEF];
    logic [CBITS-1:0]       active_r [2][NCOEF];
    logic [1:0]             upd_pend_r;
    logic [NCOEF*CBITS-1:0] coef0_s, coef1_s;
    logic [NSAMP*NBITS-1:0] mid_s;

    assign req_s    = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s     = req_s & wb_we_i;
    assign bank_s   = wb_adr_i[7];
    assign wb_ack_o = ack_r;
    assign wb_dat_o = 32'd0;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign unused_s = ^{wb_sel_i, wb_dat_i[31:18]};

    // Decode the register offset into a sequenced register index or an update command
    always_comb begin
        seq_hit_s = 1'b1;
        seq_idx_s = 3'd0;
        upd_cmd_s = 1'b0;
        case (wb_adr_i[6:0])
            7'h00: begin
                seq_hit_s = 1'b0;
                upd_cmd_s = wb_dat_i[0];
            end
            7'h04:   seq_idx_s = 3'd0;
            7'h08:   seq_idx_s = 3'd1;
            7'h0C:   seq_idx_s = 3'd2;
            7'h10:   seq_idx_s = 3'd3;
            7'h14:   seq_idx_s = 3'd4;
            7'h18:   seq_idx_s = 3'd5;
            7'h1C:   seq_idx_s = 3'd6;
            default: seq_hit_s = 1'b0;
        endcase
        wr_idx_s = seq_base(seq_idx_s) + {2'b00, ptr_r[bank_s][seq_idx_s]};
    end

    // Wishbone acknowledge: one-cycle pulse per request
    always_ff @(posedge aclk or posedge reset_BQ_i) begin
        if (reset_BQ_i) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= req_s;
        end
    end

    // Per-register write pointers; an update command rewinds every pointer of its bank
    always_ff @(posedge aclk or posedge reset_BQ_i) begin
        if (reset_BQ_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 7; r++) begin
                    ptr_r[b][r] <= 3'd0;
                end
            end
        end else if (wr_s && upd_cmd_s) begin
            for (int r = 0; r < 7; r++) begin
                ptr_r[bank_s][r] <= 3'd0;
            end
        end else if (wr_s && seq_hit_s) begin
            ptr_r[bank_s][seq_idx_s] <= (ptr_r[bank_s][seq_idx_s] == seq_last(seq_idx_s))
                                        ? 3'd0 : ptr_r[bank_s][seq_idx_s] + 3'd1;
        end
    end

    // Shadow writes and the deferred shadow-to-active copy; the copy sees the pre-write shadow
    always_ff @(posedge aclk) begin
        for (int b = 0; b < 2; b++) begin
            if (upd_pend_r[b]) begin
                for (int k = 0; k < NCOEF; k++) begin
                    active_r[b][k] <= shadow_r[b][k];
                end
            end
        end
        if (wr_s && seq_hit_s) begin
            shadow_r[bank_s][wr_idx_s] <= wb_dat_i[CBITS-1:0];
        end
        upd_pend_r <= {wr_s & upd_cmd_s & bank_s, wr_s & upd_cmd_s & ~bank_s};
    end

    // Flatten the active banks for the two stages
    always_comb begin
        for (int k = 0; k < NCOEF; k++) begin
            coef0_s[k*CBITS +: CBITS] = active_r[0][k];
            coef1_s[k*CBITS +: CBITS] = active_r[1][k];
        end
    end

    trigger_chain_stage #(.NSAMP(NSAMP), .NBITS(NBITS), .CBITS(CBITS), .FRAC(FRAC), .NCOEF(NCOEF))
    u_stage0 (.aclk(aclk), .reset_BQ_i(reset_BQ_i), .coef(coef0_s), .x(dat_i), .y(mid_s));

    trigger_chain_stage #(.NSAMP(NSAMP), .NBITS(NBITS), .CBITS(CBITS), .FRAC(FRAC), .NCOEF(NCOEF))
    u_stage1 (.aclk(aclk), .reset_BQ_i(reset_BQ_i), .coef(coef1_s), .x(mid_s), .y(dat_o));
endmodule

// File: tb/tb_trigger_chain_design.sv
// Directed, table-driven bench for trigger_chain_design with hand-computed filter responses.

module tb_trigger_chain_design;
    logic        aclk = 1'b0;
    logic        reset_BQ_i, wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [95:0] dat_i, dat_o;

    typedef struct {
        string       name;
        logic [95:0] din;
        logic [95:0] dexp;
    } vec_t;

    vec_t        tbl [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_cnt;
    logic [31:0] last_rdat;

    trigger_chain_design dut (
        .aclk(aclk), .reset_BQ_i(reset_BQ_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .dat_i(dat_i), .dat_o(dat_o)
    );

    always #5 aclk = ~aclk;

    function automatic logic [95:0] pk(input int s0, input int s1, input int s2, input int s3,
                                       input int s4, input int s5, input int s6, input int s7);
        int          s [8];
        logic [95:0] r;
        s = '{s0, s1, s2, s3, s4, s5, s6, s7};
        for (int k = 0; k < 8; k++) r[12*k +: 12] = s[k][11:0];
        return r;
    endfunction

    function automatic logic [95:0] rep(input int v);
        return pk(v, v, v, v, v, v, v, v);
    endfunction

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic add(input string nm, input logic [95:0] din, input logic [95:0] dexp);
        tbl.push_back('{nm, din, dexp});
    endtask

    // Drives the queued blocks back to back; each output appears 4 clocks after its block
    task automatic run_table(input string tag);
        int nb;
        nb = tbl.size();
        for (int i = 0; i < nb + 4; i++) begin
            dat_i = (i < nb) ? tbl[i].din : 96'd0;
            step();
            if (i >= 3 && i - 3 < nb)
                check($sformatf("%s[%0d] %s", tag, i - 3, tbl[i-3].name), dat_o, tbl[i-3].dexp);
        end
        dat_i = 96'd0;
        tbl.delete();
    endtask

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] d);
        bit seen;
        seen     = 1'b0;
        ack_cnt  = 0;
        wb_adr_i = adr;
        wb_dat_i = d;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int t = 0; t < 8 && !seen; t++) begin
            step();
            if (wb_ack_o) begin
                seen      = 1'b1;
                ack_cnt   = 1;
                last_rdat = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_ack_timeout adr=%h got no ack expected ack", adr);
        end
        for (int t = 0; t < 3; t++) begin
            step();
            if (wb_ack_o) ack_cnt++;
        end
    endtask

    task automatic wr(input logic [7:0] adr, input int v);
        wb_xfer(1'b1, adr, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_BQ_i = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = 4'hF; wb_adr_i = 8'h00; wb_dat_i = 32'd0;
        dat_i = 96'd0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_dat_o", dat_o, 96'd0);
        check("reset_ack", {95'd0, wb_ack_o}, 96'd0);
        reset_BQ_i = 1'b0;
        step();

        // Power-up coefficients are zero: both stages pass samples straight through
        add("const100", rep(100), rep(100));
        add("mixed", pk(0, 1, -1, 2047, -2048, 5, -300, 1000), pk(0, 1, -1, 2047, -2048, 5, -300, 1000));
        add("max", rep(2047), rep(2047));
        add("min", rep(-2048), rep(-2048));
        add("alt", pk(-7, 7, -700, 700, 1, -1, 2046, -2047), pk(-7, 7, -700, 700, 1, -1, 2046, -2047));
        run_table("pass");

        // B = -1.0 in shadow only; a read in between must not disturb anything
        wr(8'h04, -16384);
        check("ack_pulse_count", ack_cnt, 96'd1);
        wb_xfer(1'b0, 8'h04, 32'd0);
        check("read_data", {64'd0, last_rdat}, 96'd0);
        check("read_ack_count", ack_cnt, 96'd1);
        add("impulse_no_update", pk(512, 0, 0, 0, 0, 0, 0, 0), pk(512, 0, 0, 0, 0, 0, 0, 0));
        run_table("shadow");

        wr(8'h00, 1);
        add("impulse_l0", pk(512, 0, 0, 0, 0, 0, 0, 0), pk(512, -512, 0, 0, 0, 0, 0, 0));
        add("zeros", rep(0), rep(0));
        add("impulse_l7", pk(0, 0, 0, 0, 0, 0, 0, 512), pk(0, 0, 0, 0, 0, 0, 0, 512));
        add("carry_l7", rep(0), pk(-512, 0, 0, 0, 0, 0, 0, 0));
        run_table("notchB");

        // B = A = 1.0: three-tap sum saturates
        wr(8'h04, 16384);
        wr(8'h04, 16384);
        wr(8'h00, 1);
        add("pos_first", rep(2000), pk(2000, 2047, 2047, 2047, 2047, 2047, 2047, 2047));
        add("pos_steady", rep(2000), rep(2047));
        add("neg_first", rep(-2000), pk(2000, -2000, -2048, -2048, -2048, -2048, -2048, -2048));
        add("neg_steady", rep(-2000), rep(-2048));
        run_table("sat");

        // Mid-stream reset clears history but keeps coefficients
        wr(8'h04, -16384);
        wr(8'h04, 0);
        wr(8'h00, 1);
        dat_i = rep(300);
        repeat (6) step();
        reset_BQ_i = 1'b1;
        #1;
        check("reset_immediate", dat_o, 96'd0);
        repeat (32) step();
        check("reset_held", dat_o, 96'd0);
        dat_i = 96'd0;
        reset_BQ_i = 1'b0;
        add("post_reset_zero0", rep(0), rep(0));
        add("post_reset_zero1", rep(0), rep(0));
        add("post_reset_impulse", pk(512, 0, 0, 0, 0, 0, 0, 0), pk(512, -512, 0, 0, 0, 0, 0, 0));
        run_table("rst");

        // Bank 1 B = -1.0 cascades with stage 0
        wr(8'h84, -16384);
        wr(8'h80, 1);
        add("cascade_impulse", pk(512, 0, 0, 0, 0, 0, 0, 0), pk(512, -1024, 512, 0, 0, 0, 0, 0));
        add("cascade_tail", rep(0), rep(0));
        run_table("bank1");
        wr(8'h84, 0);
        wr(8'h80, 1);

        // Pole section: C_0 = a1' = 0.5, F1 = 1.0, zero section cleared
        wr(8'h04, 0);
        wr(8'h04, 0);
        wr(8'h08, 0);
        wr(8'h08, 0);
        wr(8'h08, 0);
        wr(8'h08, 8192);
        wr(8'h0C, 8192);
        wr(8'h0C, 0);
        for (int k = 0; k < 6; k++) wr(8'h10, 0);
        wr(8'h10, 16384);
        wr(8'h00, 1);
        add("a1_decay", pk(512, 0, 0, 0, 0, 0, 0, 0), pk(512, 256, 128, 64, 32, 16, 0, 0));
        add("f1_tap", pk(0, 0, 0, 0, 0, 100, 0, 0), pk(0, 0, 0, 0, 0, 100, 100, 0));
        add("y7_seed", pk(0, 0, 0, 0, 0, 0, 0, 512), pk(0, 0, 0, 0, 0, 0, 0, 512));
        add("c0_feedback", rep(0), pk(256, 0, 0, 0, 0, 0, 0, 0));
        add("settled", rep(0), rep(0));
        run_table("poles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trigger_chain_design.md
Name: trigger_chain_design

Overview:
- Two-stage cascaded 8-sample-parallel biquad notch filter for the trigger path: 8 × 12-bit ADC samples in per clock, 8 filtered samples out.
- Coefficients are loaded over a Wishbone slave into shadow registers, then made active with an update write.
- Sits between the ADC sample stream and the trigger logic.

Parameters:
NSAMP, 8, samples per clock.
NBITS, 12, signed sample width.
CBITS, 18, signed coefficient width (low 18 bits of each write).
FRAC, 14, coefficient fraction bits (Q4.14; 16384 = 1.0).

Ports:
aclk  in  1  single clock for the datapath and Wishbone.
reset_BQ_i  in  1  asynchronous active-high reset.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_we_i  in  1  write enable.
wb_sel_i  in  4  byte selects (ignored; full-word writes).
wb_adr_i  in  8  byte address; bit7 = stage/bank, bits6:0 = register.
wb_dat_i  in  32  write data.
wb_ack_o  out  1  acknowledge.
wb_dat_o  out  32  read data (always 0).
wb_err_o, wb_rty_o  out  1  tied 0.
dat_i  in  96  sample k = dat_i[12k+:12], signed; k=0 is oldest.
dat_o  out  96  filtered samples, same packing.

Behaviour:
- Ack: ack <= cyc & stb & ~ack, giving a one-cycle pulse per request. A write takes effect only on the cycle ack rises. Reads ack and return 0.
- Registers per bank (offsets). Each sequenced register has its own write pointer, wrapping modulo its length:
  - 0x04: B, A.
  - 0x08: C_2, C_3, C_1, C_0.
  - 0x0C: a1', a2'.
  - 0x10: D_FF, F6..F1.
  - 0x14: E_GG, G7..G1.
  - 0x18: D_FG.
  - 0x1C: E_GF.
- 0x00 with bit0=1: copy that bank's shadow to active on the next clock and zero all of that bank's pointers. Unmapped offsets ack with no effect.
- Coefficients are stored sign-extended from bits 17:0.
- Shadow and active banks have power-up value 0 and are NOT cleared by reset_BQ_i.
- All-zero coefficients make each stage a pure pass-through.
- Per stage, with input x, z the zero-section output, y the stage output, y_-1/y_-2 = previous block's y7/y6, and >>> arithmetic shift by FRAC:
  - zero section: z_n = x_n + (B·x_{n-1} + A·x_{n-2}) >>> 14, using history across blocks; then register.
  - y0 = z0 + (C_0·y_-1 + C_1·y_-2) >>> 14.
  - y1 = z1 + (C_2·y_-1 + C_3·y_-2 + a1'·z0) >>> 14.
  - y2..y5 = z_n + (a1'·y_{n-1} + a2'·y_{n-2}) >>> 14.
  - y6 = z6 + (ΣF_k·z_{6-k}, k=1..6, + D_FF·y_-2 + E_GF·y_-1) >>> 14.
  - y7 = z7 + (ΣG_k·z_{7-k}, k=1..7, + E_GG·y_-1 + D_FG·y_-2) >>> 14.
  - Register the outputs.
- Internal arithmetic is at least 48 bits. Each stage output saturates to [-2048, 2047].
- Chain: stage0 (bank 0x00) feeds stage1 (bank 0x80). Latency is 2 clocks per stage, so dat_i to dat_o is 4 aclk cycles. Full throughput, no stalls.
- reset_BQ_i:
  - Asynchronously clears all sample history, y_-1/y_-2, pipeline registers, dat_o (=0), wb_ack_o (=0) and all write pointers.
  - Coefficients are retained.
  - Held ≥1 cycle, after which processing resumes from zero history.
- An update coinciding with a coefficient write: the update copies the pre-write shadow, and the write lands in shadow afterwards.

Test Plan:
- Power-up, no writes, all lanes dat_i=100 -> after 4 clocks every dat_o lane = 100.
- Single write to 0x04 -> wb_ack_o high exactly one cycle. Write held until ack -> exactly one register written.
- Bank0 B=-16384, others 0, update written. Impulse 512 on lane 0 of one block (else 0) -> 4 clocks later lane0=512, lane1=-512 (0xE00), rest 0.
- Write B=-16384 without update -> output stays pass-through (impulse 512 -> single 512). After the 0x00 write -> the impulse response of the previous case.
- Bank0 B=A=16384, constant x=2000 -> dat_o = 2047. Constant x=-2000 -> -2048 (0x800).
- Mid-stream reset_BQ_i pulse of 32 clocks -> dat_o=0 immediately. With input 0 after release, output 0 (history cleared). Previous coefficients still produce the same impulse response without reloading.
